// File: rtl/bsg_cache_nb_dma_arbiter.sv
// Round-robin arbiter that lends the single cache DMA port to one requester for a
// whole multi-command transaction, routing the engine's done pulse back to the owner.
package bsg_cache_nb_dma_pkg;
   typedef enum logic [2:0] {
      e_dma_nop              = 3'd0,
      e_dma_send_fill_addr   = 3'd1,
      e_dma_send_refill_addr = 3'd2,
      e_dma_send_evict_addr  = 3'd3,
      e_dma_get_fill_data    = 3'd4,
      e_dma_send_evict_data  = 3'd5
   } bsg_cache_nb_dma_cmd_e;
endpackage

module bsg_cache_nb_dma_arbiter
   import bsg_cache_nb_dma_pkg::*;
#(
   parameter int num_req_p     = 2,
   parameter int addr_width_p  = 32,
   parameter int lg_num_req_lp = (num_req_p == 1) ? 1 : $clog2(num_req_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [num_req_p-1:0]     req_v_i,
   input  bsg_cache_nb_dma_cmd_e    req_dma_cmd_i  [num_req_p],
   input  logic [addr_width_p-1:0]  req_dma_addr_i [num_req_p],
   input  logic [num_req_p-1:0]     req_last_i,
   output logic [num_req_p-1:0]     grant_o,
   output logic [num_req_p-1:0]     req_dma_done_o,
   output bsg_cache_nb_dma_cmd_e    dma_cmd_o,
   output logic [addr_width_p-1:0]  dma_addr_o,
   input  logic                     dma_done_i,
   output logic [lg_num_req_lp-1:0] owner_id_o,
   output logic                     busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_e;

   state_e                   r_state, w_state_next;
   logic [lg_num_req_lp-1:0] r_owner, w_owner_next;
   logic [lg_num_req_lp-1:0] r_rr_ptr, w_rr_ptr_next;

   logic [lg_num_req_lp-1:0] w_cand_idx [num_req_p];
   logic [num_req_p-1:0]     w_cand_hit;
   logic [lg_num_req_lp-1:0] w_winner;
   logic [lg_num_req_lp-1:0] w_release_ptr;
   logic                     w_owner_v;
   logic                     w_owner_last;
   bsg_cache_nb_dma_cmd_e    w_owner_cmd;
   logic [addr_width_p-1:0]  w_owner_addr;

   // Candidate gi is the requester gi places above rr_ptr, wrapping modulo num_req_p.
   genvar gi;
   generate
      for (gi = 0; gi < num_req_p; gi++) begin : g_cand
         assign w_cand_idx[gi] = lg_num_req_lp'((int'(r_rr_ptr) + gi) % num_req_p);
         assign w_cand_hit[gi] = req_v_i[w_cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      w_winner = '0;
      for (int i = num_req_p - 1; i >= 0; i--) begin
         if (w_cand_hit[i]) w_winner = w_cand_idx[i];
      end
   end

   assign w_release_ptr = lg_num_req_lp'((int'(r_owner) + 1) % num_req_p);
   assign w_owner_v     = req_v_i[r_owner];
   assign w_owner_last  = req_last_i[r_owner];
   assign w_owner_cmd   = req_dma_cmd_i[r_owner];
   assign w_owner_addr  = req_dma_addr_i[r_owner];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state  <= S_IDLE;
         r_owner  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_next;
         r_owner  <= w_owner_next;
         r_rr_ptr <= w_rr_ptr_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_owner_next   = r_owner;
      w_rr_ptr_next  = r_rr_ptr;
      grant_o        = '0;
      req_dma_done_o = '0;
      dma_cmd_o      = e_dma_nop;
      dma_addr_o     = '0;
      owner_id_o     = '0;
      busy_o         = 1'b0;

      // Owned states share grant and forwarding; the engine never sees an address with a nop.
      if (r_state != S_IDLE) begin
         grant_o    = num_req_p'(1) << r_owner;
         owner_id_o = r_owner;
         busy_o     = 1'b1;
         if (w_owner_v) begin
            dma_cmd_o  = w_owner_cmd;
            dma_addr_o = (w_owner_cmd != e_dma_nop) ? w_owner_addr : '0;
         end
      end

      case (r_state)
         S_IDLE: begin
            if (|req_v_i) begin
               w_owner_next = w_winner;
               w_state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            if (dma_done_i) begin
               req_dma_done_o = num_req_p'(1) << r_owner;
               if (w_owner_last) begin
                  w_state_next  = S_IDLE;
                  w_rr_ptr_next = w_release_ptr;
               end else begin
                  w_state_next  = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (w_owner_v) w_state_next = S_BUSY;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bsg_cache_nb_dma_arbiter.sv
// Bench for the DMA arbiter: directed scenarios plus random traffic on a 2- and a
// 3-requester instance, all compared against a transaction-level ownership model.
module tb_bsg_cache_nb_dma_arbiter;
   import bsg_cache_nb_dma_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // Shared stimulus; each instance uses the first num_req_p entries.
   logic [7:0]            s_v, s_last;
   logic                  s_done;
   bsg_cache_nb_dma_cmd_e s_cmd  [8];
   logic [31:0]           s_addr [8];
   int                    sel;

   bsg_cache_nb_dma_cmd_e d2_cmd [2];
   logic [31:0]           d2_addr [2];
   bsg_cache_nb_dma_cmd_e d3_cmd [3];
   logic [31:0]           d3_addr [3];
   always_comb begin
      for (int i = 0; i < 2; i++) begin d2_cmd[i] = s_cmd[i]; d2_addr[i] = s_addr[i]; end
      for (int i = 0; i < 3; i++) begin d3_cmd[i] = s_cmd[i]; d3_addr[i] = s_addr[i]; end
   end

   logic [1:0] g2, dn2;
   bsg_cache_nb_dma_cmd_e c2;
   logic [31:0] a2;
   logic [0:0]  o2;
   logic        b2;
   logic [2:0]  g3, dn3;
   bsg_cache_nb_dma_cmd_e c3;
   logic [31:0] a3;
   logic [1:0]  o3;
   logic        b3;

   bsg_cache_nb_dma_arbiter #(.num_req_p(2), .addr_width_p(32)) u_dut2 (
      .clk_i(clk), .reset_n_i(reset_n), .req_v_i(s_v[1:0]), .req_dma_cmd_i(d2_cmd),
      .req_dma_addr_i(d2_addr), .req_last_i(s_last[1:0]), .grant_o(g2),
      .req_dma_done_o(dn2), .dma_cmd_o(c2), .dma_addr_o(a2), .dma_done_i(s_done),
      .owner_id_o(o2), .busy_o(b2));

   bsg_cache_nb_dma_arbiter #(.num_req_p(3), .addr_width_p(32)) u_dut3 (
      .clk_i(clk), .reset_n_i(reset_n), .req_v_i(s_v[2:0]), .req_dma_cmd_i(d3_cmd),
      .req_dma_addr_i(d3_addr), .req_last_i(s_last[2:0]), .grant_o(g3),
      .req_dma_done_o(dn3), .dma_cmd_o(c3), .dma_addr_o(a3), .dma_done_i(s_done),
      .owner_id_o(o3), .busy_o(b3));

   logic [7:0]  obs_grant, obs_done;
   logic [2:0]  obs_cmd, obs_owner;
   logic [31:0] obs_addr;
   logic        obs_busy;
   always_comb begin
      if (sel == 0) begin
         obs_grant = {6'b0, g2}; obs_done = {6'b0, dn2}; obs_cmd = c2;
         obs_addr = a2; obs_owner = {2'b0, o2}; obs_busy = b2;
      end else begin
         obs_grant = {5'b0, g3}; obs_done = {5'b0, dn3}; obs_cmd = c3;
         obs_addr = a3; obs_owner = {1'b0, o3}; obs_busy = b3;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Ownership model: who holds the port, whether it is between commands, and
   // where the next round-robin search starts.
   int nreq;
   bit m_owned, m_between;
   int m_owner, m_ptr;

   task automatic model_reset();
      m_owned = 0; m_between = 0; m_owner = 0; m_ptr = 0;
   endtask

   task automatic model_clock();
      if (!reset_n) begin
         model_reset();
      end else if (!m_owned) begin
         for (int k = 0; k < nreq; k++) begin
            if (s_v[(m_ptr + k) % nreq]) begin
               m_owner = (m_ptr + k) % nreq;
               m_owned = 1;
               break;
            end
         end
      end else if (m_between) begin
         if (s_v[m_owner]) m_between = 0;
      end else if (s_done) begin
         if (s_last[m_owner]) begin
            m_owned = 0;
            m_ptr   = (m_owner + 1) % nreq;
         end else begin
            m_between = 1;
         end
      end
   endtask

   task automatic compare_all();
      logic [7:0]  eg, ed;
      logic [2:0]  ec, eo;
      logic [31:0] ea;
      logic        eb;
      eg = 0; ed = 0; ec = 0; eo = 0; ea = 0; eb = 0;
      if (m_owned) begin
         eg = 8'(1 << m_owner);
         eo = 3'(m_owner);
         eb = 1;
         if (s_v[m_owner]) begin
            ec = s_cmd[m_owner];
            if (ec != 3'(e_dma_nop)) ea = s_addr[m_owner];
         end
         if (!m_between && s_done) ed = eg;
      end
      check("grant", 32'(obs_grant), 32'(eg));
      check("req_done", 32'(obs_done), 32'(ed));
      check("dma_cmd", 32'(obs_cmd), 32'(ec));
      check("dma_addr", obs_addr, ea);
      check("owner_id", 32'(obs_owner), 32'(eo));
      check("busy", 32'(obs_busy), 32'(eb));
      check("grant_onehot0", 32'($onehot0(obs_grant)), 32'd1);
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic cycle();
      #1 compare_all();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      s_v = 0; s_last = 0; s_done = 0;
      for (int i = 0; i < 8; i++) begin s_cmd[i] = e_dma_nop; s_addr[i] = 0; end
   endtask

   task automatic set_req(input int i, input bit v, input bsg_cache_nb_dma_cmd_e c,
                          input logic [31:0] a, input bit l);
      s_v[i] = v; s_cmd[i] = c; s_addr[i] = a; s_last[i] = l;
   endtask

   task automatic do_reset(input int s);
      reset_n = 0;
      clear_inputs();
      sel  = s;
      nreq = (s == 0) ? 2 : 3;
      model_reset();
      @(negedge clk);
      #1 compare_all();
      @(negedge clk);
      reset_n = 1;
   endtask

   int order[$];

   initial begin
      reset_n = 0;
      clear_inputs();
      sel = 0; nreq = 2;
      model_reset();

      // Single requester, one-command transaction.
      do_reset(0);
      set_req(0, 1, e_dma_send_refill_addr, 32'h1000, 1);
      cycle();
      #1 check("single_grant", 32'(obs_grant), 32'h1);
      check("single_addr", obs_addr, 32'h1000);
      s_done = 1;
      cycle();
      s_done = 0; s_v = 0;
      #1 check("single_released", 32'(obs_busy), 32'd0);
      cycle();

      // Contention from reset, then multi-command transaction with HOLD.
      do_reset(0);
      set_req(0, 1, e_dma_send_fill_addr, 32'h100, 1);
      set_req(1, 1, e_dma_send_fill_addr, 32'h200, 1);
      cycle();
      #1 check("contend_first", 32'(obs_grant), 32'h1);
      s_done = 1;
      cycle();
      s_done = 0;
      #1 check("idle_after_release", 32'(obs_busy), 32'd0);
      cycle();
      #1 check("contend_second", 32'(obs_grant), 32'h2);
      set_req(1, 1, e_dma_send_evict_addr, 32'h2000, 0);
      s_done = 1;
      cycle();
      s_v[1] = 0;
      #1 check("hold_grant", 32'(obs_grant), 32'h2);
      check("hold_cmd", 32'(obs_cmd), 32'(e_dma_nop));
      check("hold_spurious_done", 32'(obs_done), 32'd0);
      cycle();
      s_done = 0;
      set_req(1, 1, e_dma_send_evict_data, 32'h2040, 1);
      #1 check("hold_forward", 32'(obs_cmd), 32'(e_dma_send_evict_data));
      cycle();
      s_done = 1;
      cycle();
      s_done = 0; s_v[1] = 0;
      cycle();
      #1 check("wrap_to_0", 32'(obs_grant), 32'h1);
      s_done = 1;
      cycle();
      s_done = 0; s_v = 0;
      cycle();

      // Asynchronous reset between edges while BUSY.
      set_req(0, 1, e_dma_send_fill_addr, 32'h3000, 0);
      cycle();
      s_done = 1;
      #2 reset_n = 0;
      model_reset();
      #1 compare_all();
      check("async_rst_done", 32'(obs_done), 32'd0);
      @(negedge clk);
      reset_n = 1;
      clear_inputs();
      set_req(1, 1, e_dma_send_fill_addr, 32'h4000, 1);
      cycle();
      #1 check("post_reset_grant", 32'(obs_grant), 32'h2);
      cycle();

      // Three requesters, everyone always requesting single-command transactions.
      do_reset(1);
      for (int i = 0; i < 3; i++) set_req(i, 1, e_dma_send_fill_addr, 32'(16 * i), 1);
      s_done = 1;
      for (int k = 0; k < 8; k++) begin
         #1 if (obs_busy) order.push_back(int'(obs_owner));
         cycle();
      end
      check("rr3_count", 32'(order.size()), 32'd4);
      if (order.size() == 4) begin
         check("rr3_0", 32'(order[0]), 32'd0);
         check("rr3_1", 32'(order[1]), 32'd1);
         check("rr3_2", 32'(order[2]), 32'd2);
         check("rr3_3", 32'(order[3]), 32'd0);
      end

      // Random traffic on both instances.
      for (int s = 0; s < 2; s++) begin
         do_reset(s);
         for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 8; i++) begin
               s_v[i]    = ($urandom_range(0, 9) < 6);
               s_last[i] = ($urandom_range(0, 9) < 4);
               s_cmd[i]  = bsg_cache_nb_dma_cmd_e'($urandom_range(0, 5));
               s_addr[i] = $urandom;
            end
            s_done = ($urandom_range(0, 9) < 3);
            cycle();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bsg_cache_nb_dma_arbiter.md
BSG_CACHE_NB_DMA_ARBITER -- requirements
Module: bsg_cache_nb_dma_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2, number of DMA requesters (mgmt unit plus miss handlers); legal range 2..8.
REQ-002 SHALL have parameter addr_width_p, default 32, DMA address width.
REQ-003 SHALL have parameter lg_num_req_lp, default BSG_SAFE_CLOG2(num_req_p), owner-id width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk_i  input  1  clock; all state updates on posedge.
REQ-006 reset_n_i  input  1  asynchronous active-low reset.
REQ-007 req_v_i  input  num_req_p  per-requester command valid.
REQ-008 req_dma_cmd_i  input  num_req_p x bsg_cache_nb_dma_cmd_e  per-requester DMA command.
REQ-009 req_dma_addr_i  input  num_req_p x addr_width_p  per-requester DMA address.
REQ-010 req_last_i  input  num_req_p  current command is the last of the requester's transaction.
REQ-011 grant_o  output  num_req_p  one-hot owner of the DMA port; all zero when unowned.
REQ-012 req_dma_done_o  output  num_req_p  dma_done_i routed to the owner only.
REQ-013 dma_cmd_o  output  bsg_cache_nb_dma_cmd_e  command to the DMA engine.
REQ-014 dma_addr_o  output  addr_width_p  address to the DMA engine.
REQ-015 dma_done_i  input  1  DMA engine completed the current command.
REQ-016 owner_id_o  output  lg_num_req_lp  index of current owner; 0 when unowned.
REQ-017 busy_o  output  1  high in BUSY or HOLD.

Function
REQ-018 SHALL implement states IDLE, BUSY, HOLD in a registered FSM.
REQ-019 IDLE: if any req_v_i, the winner is the first set bit searching upward from rr_ptr with wrap past num_req_p-1 to 0; owner is registered, go to BUSY; grant_o asserts the cycle after the request is sampled (1-cycle grant latency).
REQ-020 IDLE with no req_v_i: stay IDLE, grant_o = 0, dma_cmd_o = e_dma_nop, dma_addr_o = 0.
REQ-021 BUSY: dma_cmd_o = owner's req_dma_cmd_i if the owner's req_v_i is set, else e_dma_nop; dma_addr_o = owner's req_dma_addr_i (0 when cmd is nop); purely combinational forwarding, no added latency.
REQ-022 BUSY with dma_done_i: req_dma_done_o[owner] = 1 that cycle; if req_last_i[owner] = 1, go to IDLE and set rr_ptr = (owner+1) mod num_req_p; else go to HOLD.
REQ-023 HOLD: owner keeps grant_o; dma_cmd_o = e_dma_nop; other requesters stay blocked; on the owner's req_v_i go to BUSY with the command forwarded the same cycle (HOLD -> BUSY forwarding is combinational).
REQ-024 dma_done_i in IDLE or HOLD SHALL be ignored; req_dma_done_o stays 0.
REQ-025 A requester de-asserting req_v_i mid-BUSY SHALL NOT release ownership; release only via done with last.
REQ-026 Release and re-arbitration SHALL NOT occur in the same cycle: one IDLE cycle always follows a release, even with requests pending.
REQ-027 Non-owners SHALL never see req_dma_done_o or grant_o; grant_o is one-hot or zero at all times.
REQ-028 rr_ptr SHALL change only on release and SHALL wrap correctly for non-power-of-two num_req_p.

Reset
REQ-029 While reset_n_i = 0 (asynchronously): state IDLE, rr_ptr 0, owner 0, grant_o 0, req_dma_done_o 0, dma_cmd_o e_dma_nop, dma_addr_o 0, owner_id_o 0, busy_o 0.
REQ-030 Reset mid-BUSY/HOLD SHALL abandon the transaction with no done pulse; after release, the first arbitration starts from rr_ptr 0.

Verification
REQ-031 Single: req_v_i=01, cmd e_dma_send_refill_addr, addr 0x1000, last=1 -> cycle+1 grant_o=01, dma_addr_o=0x1000; done -> req_dma_done_o=01, IDLE, rr_ptr=1.
REQ-032 Contention: req_v_i=11 from reset -> requester 0 wins; after its last-done, one IDLE cycle, then requester 1 granted (rr_ptr=1).
REQ-033 Multi-command: owner 1 sends evict_addr (last=0), done -> HOLD with grant_o=10 while requester 0 requests; evict_data (last=1) done -> IDLE, rr_ptr=0 (wrap, num_req_p=2).
REQ-034 Spurious done: dma_done_i pulsed in IDLE and HOLD -> req_dma_done_o=0, state unchanged.
REQ-035 Reset mid-BUSY: assert reset_n_i=0 asynchronously between clock edges -> outputs immediately at reset values, no done pulse; after deassert, req_v_i=10 -> grant_o=10 after 1 cycle.
REQ-036 num_req_p=3: all requesting with last=1 each time -> grant order 0,1,2,0, proving wrap from 2 to 0.
